// File: rtl/mem_ctrl_arb_pkg.sv
// Shared types and size helpers for the memory-controller arbiter.
package mem_ctrl_arb_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_RSVD  = 2'b10,
    OP_WRITE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_READY,
    ST_RD_HOST,
    ST_RD_DRAIN,
    ST_WR_FILL,
    ST_WR_BUBBLE,
    ST_WR_HOST
  } state_e;

  // Number of CPU words per host cache line.
  function automatic int unsigned fill_count(input int unsigned cl_width,
                                             input int unsigned word_size);
    return cl_width / word_size;
  endfunction

  // Counter width able to index every word of a line (at least one bit).
  function automatic int unsigned fill_bits(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority moves past the last winner on advance.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant_c
);

  localparam int unsigned PTR_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_BITS-1:0] ptr;
  logic [PTR_BITS-1:0] win;
  logic [PTR_BITS-1:0] idx;
  logic                found;
  int unsigned         sum;

  // Scan channels starting at the pointer; first requester wins.
  always_comb begin
    grant_c = '0;
    win     = '0;
    found   = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = PTR_BITS'(sum);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        win          = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win == PTR_BITS'(NUM_CH - 1)) ? '0 : win + PTR_BITS'(1);
    end
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-channel word-to-cache-line bridge in front of a host memory link.
// Optional host-wait timeout enabled by defining MEM_CTRL_ARB_TIMEOUT_EN.
module mem_ctrl_arb
  import mem_ctrl_arb_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned CL_SIZE_WIDTH  = 512,
  parameter int unsigned ADDR_BITCOUNT  = 64,
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          host_init,
  input  logic                          host_rd_ready,
  input  logic                          host_wr_ready,
  input  logic [ADDR_BITCOUNT-1:0]      address_offset,
  input  logic [CL_SIZE_WIDTH-1:0]      host_data_bus_read_in,
  output logic [CL_SIZE_WIDTH-1:0]      host_data_bus_write_out,
  output logic [ADDR_BITCOUNT-1:0]      corrected_address,
  output logic                          host_rgo,
  output logic                          host_wgo,
  output logic                          host_re,
  output logic                          host_we,
  input  logic [2*NUM_CH-1:0]           req_op,
  input  logic [ADDR_BITCOUNT*NUM_CH-1:0] req_addr,
  input  logic [WORD_SIZE*NUM_CH-1:0]   wr_data,
  output logic [WORD_SIZE-1:0]          rd_data,
  output logic [NUM_CH-1:0]             grant,
  output logic                          ready,
  output logic                          rd_valid,
  output logic                          tx_done,
  output logic                          err
);

  localparam int unsigned FILL_COUNT = fill_count(CL_SIZE_WIDTH, WORD_SIZE);
  localparam int unsigned FILL_BITS  = fill_bits(FILL_COUNT);

  if (NUM_CH < 1 || NUM_CH > 8 || WORD_SIZE == 0 || (CL_SIZE_WIDTH % WORD_SIZE) != 0 ||
      TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("mem_ctrl_arb: illegal parameter set");
  end

  state_e                   state, state_d;
  logic [FILL_BITS-1:0]     cnt;
  logic [CL_SIZE_WIDTH-1:0] line;
  logic [NUM_CH-1:0]        grant_q;
  logic [NUM_CH-1:0]        req_vec_c;
  logic [NUM_CH-1:0]        arb_grant_c;
  logic [ADDR_BITCOUNT-1:0] sel_addr_c;
  logic                     sel_write_c;
  logic [WORD_SIZE-1:0]     wr_word_c;
  logic [WORD_SIZE-1:0]     line_words [FILL_COUNT];
  logic                     advance_c, cap_line_c, shift_line_c, cnt_inc_c, cnt_last_c;
  logic                     timeout_c;

  // Per-channel request decode plus muxes for the arbitration winner and current owner.
  always_comb begin
    req_vec_c   = '0;
    sel_addr_c  = '0;
    sel_write_c = 1'b0;
    wr_word_c   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req_vec_c[i] = (req_op[2*i +: 2] == OP_READ) || (req_op[2*i +: 2] == OP_WRITE);
      if (arb_grant_c[i]) begin
        sel_addr_c  = sel_addr_c | req_addr[i*ADDR_BITCOUNT +: ADDR_BITCOUNT];
        sel_write_c = sel_write_c | (req_op[2*i +: 2] == OP_WRITE);
      end
      if (grant_q[i]) wr_word_c = wr_word_c | wr_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < FILL_COUNT; i++) begin
      line_words[i] = line[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vec_c),
    .advance (advance_c),
    .grant_c (arb_grant_c)
  );

  assign cnt_last_c = (cnt == FILL_BITS'(FILL_COUNT - 1));

`ifdef MEM_CTRL_ARB_TIMEOUT_EN
  localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_BITS-1:0] tcnt;
  logic               host_wait_c;

  assign host_wait_c = (state == ST_RD_HOST) || (state == ST_WR_HOST);
  assign timeout_c   = host_wait_c && (tcnt == TO_BITS'(TIMEOUT_CYCLES - 1));

  // Counts consecutive cycles spent waiting on the host; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (host_wait_c && state_d == state) begin
      tcnt <= tcnt + TO_BITS'(1);
    end else begin
      tcnt <= '0;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_STARTUP;
    else        state <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d      = state;
    host_rgo     = 1'b0;
    host_wgo     = 1'b0;
    host_re      = 1'b0;
    host_we      = 1'b0;
    rd_valid     = 1'b0;
    rd_data      = '0;
    tx_done      = 1'b0;
    err          = 1'b0;
    advance_c    = 1'b0;
    cap_line_c   = 1'b0;
    shift_line_c = 1'b0;
    cnt_inc_c    = 1'b0;
    unique case (state)
      ST_STARTUP: begin
        if (host_init) state_d = ST_READY;
      end
      ST_READY: begin
        if (|req_vec_c) begin
          advance_c = 1'b1;
          state_d   = sel_write_c ? ST_WR_FILL : ST_RD_HOST;
        end
      end
      ST_RD_HOST: begin
        host_rgo = 1'b1;
        if (host_rd_ready) begin
          host_re    = 1'b1;
          cap_line_c = 1'b1;
          state_d    = ST_RD_DRAIN;
        end else if (timeout_c) begin
          err     = 1'b1;
          tx_done = 1'b1;
          state_d = ST_READY;
        end
      end
      ST_RD_DRAIN: begin
        rd_valid  = 1'b1;
        rd_data   = line_words[cnt];
        cnt_inc_c = 1'b1;
        if (cnt_last_c) begin
          tx_done = 1'b1;
          state_d = ST_READY;
        end
      end
      ST_WR_FILL: begin
        shift_line_c = 1'b1;
        cnt_inc_c    = 1'b1;
        if (cnt_last_c) state_d = ST_WR_BUBBLE;
      end
      ST_WR_BUBBLE: begin
        host_wgo = 1'b1;
        state_d  = ST_WR_HOST;
      end
      ST_WR_HOST: begin
        host_wgo = 1'b1;
        if (host_wr_ready) begin
          host_we = 1'b1;
          tx_done = 1'b1;
          state_d = ST_READY;
        end else if (timeout_c) begin
          err     = 1'b1;
          tx_done = 1'b1;
          state_d = ST_READY;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // Owner, address, word counter and line buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q           <= '0;
      corrected_address <= '0;
      cnt               <= '0;
      line              <= '0;
    end else begin
      if (advance_c) begin
        grant_q           <= arb_grant_c;
        corrected_address <= sel_addr_c + address_offset;
      end
      if (cnt_inc_c) cnt <= cnt_last_c ? '0 : cnt + FILL_BITS'(1);
      if (cap_line_c) begin
        line <= host_data_bus_read_in;
      end else if (shift_line_c) begin
        // New word enters at the top so the first word ends up least significant.
        line <= CL_SIZE_WIDTH'({wr_word_c, line} >> WORD_SIZE);
      end
    end
  end

  assign host_data_bus_write_out = line;
  assign ready = (state != ST_STARTUP);
  assign grant = (state == ST_STARTUP || state == ST_READY) ? '0 : grant_q;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Directed bench for mem_ctrl_arb: vector table for read/write flow plus
// hand sequences for round-robin, reset abort and host-wait behaviour.
module tb_mem_ctrl_arb;

  localparam int W   = 32;
  localparam int CL  = 512;
  localparam int AB  = 64;
  localparam int NCH = 2;
  localparam int TO  = 8;

  logic            clk, rst_n;
  logic            host_init, host_rd_ready, host_wr_ready;
  logic [AB-1:0]   address_offset;
  logic [CL-1:0]   host_data_bus_read_in, host_data_bus_write_out;
  logic [AB-1:0]   corrected_address;
  logic            host_rgo, host_wgo, host_re, host_we;
  logic [2*NCH-1:0]  req_op;
  logic [AB*NCH-1:0] req_addr;
  logic [W*NCH-1:0]  wr_data;
  logic [W-1:0]    rd_data;
  logic [NCH-1:0]  grant;
  logic            ready, rd_valid, tx_done, err;

  mem_ctrl_arb #(
    .WORD_SIZE(W), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AB), .NUM_CH(NCH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host_init(host_init), .host_rd_ready(host_rd_ready),
    .host_wr_ready(host_wr_ready), .address_offset(address_offset),
    .host_data_bus_read_in(host_data_bus_read_in),
    .host_data_bus_write_out(host_data_bus_write_out),
    .corrected_address(corrected_address), .host_rgo(host_rgo), .host_wgo(host_wgo),
    .host_re(host_re), .host_we(host_we), .req_op(req_op), .req_addr(req_addr),
    .wr_data(wr_data), .rd_data(rd_data), .grant(grant), .ready(ready),
    .rd_valid(rd_valid), .tx_done(tx_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  grant;
    logic        ready, rgo, wgo, re, we, rd_valid, tx_done, err;
    logic [31:0] rd_data;
  } obs_t;

  typedef struct {
    logic        init, rrdy, wrdy;
    logic [3:0]  op;
    logic [31:0] wd;
    obs_t        exp;
    logic        chk_line;
    logic [31:0] lsw, msw;
    logic        chk_addr;
    logic [63:0] addr;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.grant = grant; o.ready = ready; o.rgo = host_rgo; o.wgo = host_wgo;
    o.re = host_re; o.we = host_we; o.rd_valid = rd_valid; o.tx_done = tx_done;
    o.err = err; o.rd_data = rd_data;
    return o;
  endfunction

  function automatic obs_t mko(input logic [1:0] g, input logic rdy, input logic rgo,
                               input logic wgo, input logic re, input logic we,
                               input logic rdv, input logic txd, input logic [31:0] rdd);
    obs_t o;
    o.grant = g; o.ready = rdy; o.rgo = rgo; o.wgo = wgo; o.re = re; o.we = we;
    o.rd_valid = rdv; o.tx_done = txd; o.err = 1'b0; o.rd_data = rdd;
    return o;
  endfunction

  function automatic vec_t mkv(input logic init, input logic rrdy, input logic wrdy,
                               input logic [3:0] op, input logic [31:0] wd, input obs_t e);
    vec_t v;
    v.init = init; v.rrdy = rrdy; v.wrdy = wrdy; v.op = op; v.wd = wd; v.exp = e;
    v.chk_line = 1'b0; v.lsw = '0; v.msw = '0; v.chk_addr = 1'b0; v.addr = '0;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    obs_t z;
    int n;
    logic seen;
    logic [1:0] alt_exp [4];
    alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    z = '0;

    // Vector table: init, ch0 read with 3-cycle host wait, ch1 write.
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 4'b0001, 32'h0, z));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, z));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 4'b0001, 32'h0,
                       mko(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)));
    for (int k = 0; k < 3; k++) begin
      v = mkv(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,
              mko(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
      if (k == 0) begin v.chk_addr = 1'b1; v.addr = 64'h1100; end
      vecs.push_back(v);
    end
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,
                       mko(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0)));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,
                         mko(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (k == 15), 32'(k))));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 4'b1100, 32'h0,
                       mko(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 4'b0000, 32'hA0 + 32'(k),
                         mko(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)));
    v = mkv(1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,
            mko(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    v.chk_line = 1'b1; v.lsw = 32'hA0; v.msw = 32'hAF; v.chk_addr = 1'b1; v.addr = 64'h1200;
    vecs.push_back(v);
    v = mkv(1'b0, 1'b0, 1'b1, 4'b0000, 32'h0,
            mko(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0));
    v.chk_line = 1'b1; v.lsw = 32'hA0; v.msw = 32'hAF;
    vecs.push_back(v);

    rst_n = 1'b0; host_init = 1'b0; host_rd_ready = 1'b0; host_wr_ready = 1'b0;
    address_offset = 64'h1000; req_op = '0; wr_data = '0;
    req_addr = {64'h200, 64'h100};
    for (int k = 0; k < 16; k++) host_data_bus_read_in[k*W +: W] = 32'(k);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(sample()), 64'(z));
    check("reset_line", 64'(|host_data_bus_write_out), 64'(0));
    check("reset_addr", corrected_address, 64'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      host_init = vecs[i].init; host_rd_ready = vecs[i].rrdy; host_wr_ready = vecs[i].wrdy;
      req_op = vecs[i].op; wr_data = {vecs[i].wd, vecs[i].wd};
      #1;
      check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].exp));
      if (vecs[i].chk_line) begin
        check($sformatf("vec%0d_lsw", i), 64'(host_data_bus_write_out[W-1:0]), 64'(vecs[i].lsw));
        check($sformatf("vec%0d_msw", i), 64'(host_data_bus_write_out[CL-1:CL-W]),
              64'(vecs[i].msw));
      end
      if (vecs[i].chk_addr) check($sformatf("vec%0d_addr", i), corrected_address, vecs[i].addr);
      step();
    end

    // Both channels reading continuously: grants alternate, re-arbitration right after tx_done.
    host_wr_ready = 1'b0; req_op = 4'b0101; host_rd_ready = 1'b1;
    #1;
    n = 0;
    while (grant == '0 && n < 10) begin step(); n++; end
    check("alt_grant0", 64'(grant), 64'(alt_exp[0]));
    for (int t = 1; t < 4; t++) begin
      n = 0;
      while (!tx_done && n < 40) begin step(); n++; end
      check($sformatf("alt_txdone%0d", t), 64'(tx_done), 64'(1));
      n = 0;
      do begin step(); n++; end while (grant == '0 && n < 10);
      check($sformatf("alt_gap%0d", t), 64'(n), 64'(2));
      check($sformatf("alt_grant%0d", t), 64'(grant), 64'(alt_exp[t]));
    end
    n = 0;
    while (!tx_done && n < 40) begin step(); n++; end
    req_op = '0; host_rd_ready = 1'b0;
    step();

    // Reset while draining word 5 aborts silently and needs host_init again.
    req_op = 4'b0001; host_rd_ready = 1'b1; seen = 1'b0;
    #1;
    n = 0;
    while (!(rd_valid && rd_data == 32'd5) && n < 40) begin
      step(); n++;
      if (tx_done) seen = 1'b1;
    end
    check("rst_word5_reached", 64'(rd_valid && rd_data == 32'd5), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", 64'(sample()), 64'(z));
    check("rst_line", 64'(|host_data_bus_write_out), 64'(0));
    check("rst_addr", corrected_address, 64'h0);
    check("rst_no_txdone", 64'(seen), 64'(0));
    host_rd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("rst_startup_hold", 64'(sample()), 64'(z));
    host_init = 1'b1;
    step();
    host_init = 1'b0; req_op = '0;
    #1;
    check("rst_reinit_ready", 64'(sample()),
          64'(mko(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)));

    // Write with host never ready.
    req_op = 4'b1100; host_wr_ready = 1'b0; wr_data = {32'h55, 32'h55};
    step();
    req_op = '0;
    n = 0;
    while (!host_wgo && n < 30) begin step(); n++; end
    check("to_bubble", 64'({host_wgo, host_we}), 64'(2'b10));
    seen = 1'b0;
`ifdef MEM_CTRL_ARB_TIMEOUT_EN
    n = 1;
    for (int k = 0; k < 40; k++) begin
      step(); n++;
      if (host_we) seen = 1'b1;
      if (err) break;
    end
    check("to_err_cycle", 64'(n), 64'(9));
    check("to_err_txdone", 64'({err, tx_done}), 64'(2'b11));
    check("to_no_we", 64'(seen), 64'(0));
    step();
    check("to_back_ready", 64'(sample()),
          64'(mko(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)));
`else
    repeat (20) begin
      step();
      if (host_we || err || tx_done || !host_wgo) seen = 1'b1;
    end
    check("wait_no_err", 64'(seen), 64'(0));
    host_wr_ready = 1'b1;
    #1;
    check("wait_release", 64'({host_we, tx_done, err}), 64'(3'b110));
    step();
    host_wr_ready = 1'b0;
    check("wait_back_ready", 64'(sample()),
          64'(mko(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
